// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter
//   Shares one line-wide memory read port between two cache requesters
//   (req 0 = instruction cache, req 1 = data cache). A winner is picked in
//   IDLE, its line address is latched, and the port is held (GRANT) until
//   the memory returns the line. The response is then routed back to the
//   owner. One idle cycle always separates two transactions.
//
//   Build option: define ARB_ROUND_ROBIN_EN to break simultaneous requests
//   by round robin. Without it, requester 0 has fixed priority.
//
// Ports
//   clk_i, rst_i                    clock (rising edge), sync active-high reset
//   reqN_addr_i / reqN_read_en_i    requester N line address / read request
//   reqN_read_valid_o / _data_o     requester N returned line
//   mem_addr_o / mem_read_en_o      request to memory (non-zero only in GRANT)
//   mem_read_valid_i / _data_i      memory response
//   busy_o                          port owned (GRANT)
//   owner_o                         index of the current or last owner
//   grant_cnt0_o / grant_cnt1_o     saturating grant counters
module mem_read_arbiter #(
  parameter int unsigned LineSize  = 128,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned CntWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [AddrWidth-1:0] req0_addr_i,
  input  logic                 req0_read_en_i,
  output logic                 req0_read_valid_o,
  output logic [LineSize-1:0]  req0_read_data_o,
  input  logic [AddrWidth-1:0] req1_addr_i,
  input  logic                 req1_read_en_i,
  output logic                 req1_read_valid_o,
  output logic [LineSize-1:0]  req1_read_data_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic                 mem_read_en_o,
  input  logic                 mem_read_valid_i,
  input  logic [LineSize-1:0]  mem_read_data_i,
  output logic                 busy_o,
  output logic                 owner_o,
  output logic [CntWidth-1:0]  grant_cnt0_o,
  output logic [CntWidth-1:0]  grant_cnt1_o
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic                   owner_q, owner_d;
  logic                   last_grant_q, last_grant_d;
  logic [CntWidth-1:0]    cnt0_q, cnt0_d;
  logic [CntWidth-1:0]    cnt1_q, cnt1_d;

  logic                   winner;
  logic                   resp0, resp1;

  // Winner is only meaningful when at least one request is present.
`ifdef ARB_ROUND_ROBIN_EN
  // last_grant resets to 1, so requester 0 takes the first tie.
  always_comb begin
    if (req0_read_en_i && req1_read_en_i) winner = ~last_grant_q;
    else                                  winner = req1_read_en_i;
  end
`else
  always_comb winner = ~req0_read_en_i;
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
    unique case (state_q)
      IDLE: begin
        if (req0_read_en_i || req1_read_en_i) begin
          state_d      = GRANT;
          addr_d       = winner ? req1_addr_i : req0_addr_i;
          owner_d      = winner;
          last_grant_d = winner;
          if (!winner && cnt0_q != '1) cnt0_d = cnt0_q + CntWidth'(1);
          if ( winner && cnt1_q != '1) cnt1_d = cnt1_q + CntWidth'(1);
        end
      end
      GRANT: begin
        if (mem_read_valid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  // A response reaches the owner only if it is still requesting; otherwise
  // the line is discarded but the transaction still completes.
  always_comb begin
    resp0 = (state_q == GRANT) && mem_read_valid_i && !owner_q && req0_read_en_i;
    resp1 = (state_q == GRANT) && mem_read_valid_i &&  owner_q && req1_read_en_i;
  end

  always_comb begin
    busy_o            = (state_q == GRANT);
    mem_read_en_o     = (state_q == GRANT);
    mem_addr_o        = (state_q == GRANT) ? addr_q : '0;
    owner_o           = owner_q;
    grant_cnt0_o      = cnt0_q;
    grant_cnt1_o      = cnt1_q;
    req0_read_valid_o = resp0;
    req1_read_valid_o = resp1;
    req0_read_data_o  = resp0 ? mem_read_data_i : '0;
    req1_read_data_o  = resp1 ? mem_read_data_i : '0;
  end

endmodule
